rename_dispatch_ctrl: RTL and testbench

Sequences the register-file rename path between decoder and reservation stations.
- Per accepted instruction:
  - allocates the next ROB slot;
  - reads rs1/rs2 status from RegFile;
  - resolves operands via commit and CDB bypass;
  - drives the RegFile update port (busy + tag for rd);
  - holds the renamed instruction in a one-entry output register until the reservation stations accept it.
- Tracks ROB occupancy to generate back-pressure.
- Recovers on mispredict.

---
 rtl/rename_dispatch_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_rename_dispatch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_dispatch_ctrl.sv
// rename_dispatch_ctrl
//   Rename/dispatch sequencer between the decoder and the reservation stations.
//   For each accepted instruction it allocates the next ROB slot, resolves both
//   source operands (RegFile, then CDB bypass, then commit bypass), issues the
//   RegFile rename write for rd and holds the renamed instruction in a one-entry
//   output register until the reservation stations take it. ROB occupancy is
//   tracked for back-pressure. A mispredict flushes everything in one edge.
//
// Optional feature macro: DISPATCH_PERF_EN
//   Adds perf_stall_cnt, a saturating count of cycles in which the decoder
//   offered an instruction that could not be accepted.
//
// Ports
//   clk, rst (async, active-low), rdy (global enable), jump_wrong (flush)
//   dec_*            : decoder handshake and register indices
//   rf_rs1/rf_rs2    : RegFile read indices; rf_reg*_{ready,rob_pos} : status
//   rf_update_*      : RegFile rename write (busy + tag for rd)
//   rob_commit_*     : ROB commit broadcast (occupancy + operand bypass)
//   cdb_*            : common data bus broadcast
//   dis_*            : renamed instruction to the reservation stations
module rename_dispatch_ctrl #(
  parameter int ROB_AW    = 4,
  parameter int ROB_DEPTH = 16,
  parameter int XLEN      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_has_rd,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic              rf_reg1_ready,
  input  logic              rf_reg2_ready,
  input  logic [XLEN-1:0]   rf_reg1,
  input  logic [XLEN-1:0]   rf_reg2,
  input  logic [ROB_AW-1:0] rf_reg1_rob_pos,
  input  logic [ROB_AW-1:0] rf_reg2_rob_pos,
  output logic              rf_update_valid,
  output logic [ROB_AW-1:0] rf_update_rob_pos,
  output logic [4:0]        rf_update_rd,
  input  logic              rob_commit_valid,
  input  logic [ROB_AW-1:0] rob_commit_pos,
  input  logic [XLEN-1:0]   rob_commit_val,
  input  logic              cdb_valid,
  input  logic [ROB_AW-1:0] cdb_rob_pos,
  input  logic [XLEN-1:0]   cdb_val,
  output logic              dis_valid,
  input  logic              dis_ready,
  output logic [ROB_AW-1:0] dis_rob_pos,
  output logic [4:0]        dis_rd,
  output logic              dis_q1_wait,
  output logic [ROB_AW-1:0] dis_q1,
  output logic [XLEN-1:0]   dis_v1,
  output logic              dis_q2_wait,
  output logic [ROB_AW-1:0] dis_q2,
  output logic [XLEN-1:0]   dis_v2
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  typedef struct packed {
    logic              wait_tag;
    logic [ROB_AW-1:0] q;
    logic [XLEN-1:0]   v;
  } opnd_t;

  localparam logic [ROB_AW:0] LP_DEPTH = (ROB_AW+1)'(ROB_DEPTH);

  state_t            r_state, w_state_nxt;
  logic [ROB_AW-1:0] r_tail;
  logic [ROB_AW:0]   r_count;
  logic              r_dis_valid;
  logic [ROB_AW-1:0] r_dis_rob_pos;
  logic [4:0]        r_dis_rd;
  opnd_t             r_op1, r_op2;

  logic              w_dec_ready;
  logic              w_accept;
  logic              w_commit_dec;
  opnd_t             w_op1, w_op2;

  // Priority: x0, RegFile, CDB bypass, commit bypass, else wait on the tag.
  function automatic opnd_t f_resolve(
    input logic [4:0]        rs,
    input logic              rf_ready,
    input logic [XLEN-1:0]   rf_val,
    input logic [ROB_AW-1:0] tag,
    input logic              cv,
    input logic [ROB_AW-1:0] cpos,
    input logic [XLEN-1:0]   cval,
    input logic              mv,
    input logic [ROB_AW-1:0] mpos,
    input logic [XLEN-1:0]   mval
  );
    opnd_t o;
    o = '0;
    if (rs == 5'd0) begin
      o = '0;
    end else if (rf_ready) begin
      o.v = rf_val;
    end else if (cv && cpos == tag) begin
      o.v = cval;
    end else if (mv && mpos == tag) begin
      o.v = mval;
    end else begin
      o.wait_tag = 1'b1;
      o.q        = tag;
    end
    return o;
  endfunction

  // rst gates the handshake so nothing is offered while reset is asserted.
  always_comb begin
    w_dec_ready = rst && rdy && (r_state == S_RUN) && !jump_wrong &&
                  (r_count < LP_DEPTH) && (!r_dis_valid || dis_ready);
    w_accept     = dec_valid && w_dec_ready;
    w_commit_dec = rob_commit_valid && (r_count != '0);
    w_op1 = f_resolve(dec_rs1, rf_reg1_ready, rf_reg1, rf_reg1_rob_pos,
                      cdb_valid, cdb_rob_pos, cdb_val,
                      rob_commit_valid, rob_commit_pos, rob_commit_val);
    w_op2 = f_resolve(dec_rs2, rf_reg2_ready, rf_reg2, rf_reg2_rob_pos,
                      cdb_valid, cdb_rob_pos, cdb_val,
                      rob_commit_valid, rob_commit_pos, rob_commit_val);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (jump_wrong) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = jump_wrong ? S_FLUSH : S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // The FSM tracks jump_wrong independently of rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tail        <= '0;
      r_count       <= '0;
      r_dis_valid   <= 1'b0;
      r_dis_rob_pos <= '0;
      r_dis_rd      <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
    end else if (jump_wrong) begin
      r_tail      <= '0;
      r_count     <= '0;
      r_dis_valid <= 1'b0;
    end else if (rdy) begin
      if (w_accept && !w_commit_dec)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_commit_dec) r_count <= r_count - 1'b1;

      if (w_accept) begin
        r_tail        <= r_tail + 1'b1;
        r_dis_valid   <= 1'b1;
        r_dis_rob_pos <= r_tail;
        r_dis_rd      <= dec_has_rd ? dec_rd : 5'd0;
        r_op1         <= w_op1;
        r_op2         <= w_op2;
      end else if (r_dis_valid && dis_ready) begin
        r_dis_valid <= 1'b0;
      end else if (r_dis_valid) begin
        // Held entry snoops the CDB so it leaves with the freshest operands.
        if (r_op1.wait_tag && cdb_valid && cdb_rob_pos == r_op1.q) begin
          r_op1.wait_tag <= 1'b0;
          r_op1.v        <= cdb_val;
        end
        if (r_op2.wait_tag && cdb_valid && cdb_rob_pos == r_op2.q) begin
          r_op2.wait_tag <= 1'b0;
          r_op2.v        <= cdb_val;
        end
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] r_perf_stall;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= '0;
    end else if (rdy && r_state == S_RUN && dec_valid && !w_dec_ready &&
                 r_perf_stall != '1) begin
      r_perf_stall <= r_perf_stall + 1'b1;
    end
  end
  assign perf_stall_cnt = r_perf_stall;
`endif

  assign dec_ready         = w_dec_ready;
  assign rf_rs1            = dec_rs1;
  assign rf_rs2            = dec_rs2;
  assign rf_update_valid   = w_accept && dec_has_rd && (dec_rd != 5'd0);
  assign rf_update_rob_pos = r_tail;
  assign rf_update_rd      = dec_rd;
  assign dis_valid         = r_dis_valid;
  assign dis_rob_pos       = r_dis_rob_pos;
  assign dis_rd            = r_dis_rd;
  assign dis_q1_wait       = r_op1.wait_tag;
  assign dis_q1            = r_op1.q;
  assign dis_v1            = r_op1.v;
  assign dis_q2_wait       = r_op2.wait_tag;
  assign dis_q2            = r_op2.q;
  assign dis_v2            = r_op2.v;

endmodule

// File: tb/tb_rename_dispatch_ctrl.sv
module tb_rename_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong;
  logic        dec_valid, dec_ready, dec_has_rd;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, rf_rs1, rf_rs2;
  logic        rf_reg1_ready, rf_reg2_ready;
  logic [31:0] rf_reg1, rf_reg2;
  logic [3:0]  rf_reg1_rob_pos, rf_reg2_rob_pos;
  logic        rf_update_valid;
  logic [3:0]  rf_update_rob_pos;
  logic [4:0]  rf_update_rd;
  logic        rob_commit_valid;
  logic [3:0]  rob_commit_pos;
  logic [31:0] rob_commit_val;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;
  logic        dis_valid, dis_ready;
  logic [3:0]  dis_rob_pos, dis_q1, dis_q2;
  logic [4:0]  dis_rd;
  logic        dis_q1_wait, dis_q2_wait;
  logic [31:0] dis_v1, dis_v2;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  rename_dispatch_ctrl #(.ROB_AW(4), .ROB_DEPTH(16), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_has_rd(dec_has_rd),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_reg1_ready(rf_reg1_ready), .rf_reg2_ready(rf_reg2_ready),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2),
    .rf_reg1_rob_pos(rf_reg1_rob_pos), .rf_reg2_rob_pos(rf_reg2_rob_pos),
    .rf_update_valid(rf_update_valid), .rf_update_rob_pos(rf_update_rob_pos),
    .rf_update_rd(rf_update_rd),
    .rob_commit_valid(rob_commit_valid), .rob_commit_pos(rob_commit_pos),
    .rob_commit_val(rob_commit_val),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_rob_pos(dis_rob_pos),
    .dis_rd(dis_rd), .dis_q1_wait(dis_q1_wait), .dis_q1(dis_q1), .dis_v1(dis_v1),
    .dis_q2_wait(dis_q2_wait), .dis_q2(dis_q2), .dis_v2(dis_v2)
`ifdef DISPATCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Reference model: ROB as a queue of allocated slots, one dispatch entry.
  typedef struct { bit w; int q; logic [31:0] v; } op_t;
  int          rob_q[$];
  int          m_tail;
  bit          m_flush;
  bit          m_dv;
  int          m_pos, m_rd;
  op_t         m_o1, m_o2;
  longint      m_stall;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t resolve(input logic [4:0] rs, input logic rr,
                                  input logic [31:0] val, input logic [3:0] tag);
    op_t o;
    o = '{w: 1'b0, q: 0, v: 32'h0};
    if (rs == 0)                                      o.v = 32'h0;
    else if (rr)                                      o.v = val;
    else if (cdb_valid && cdb_rob_pos == tag)         o.v = cdb_val;
    else if (rob_commit_valid && rob_commit_pos == tag) o.v = rob_commit_val;
    else begin o.w = 1'b1; o.q = int'(tag); end
    return o;
  endfunction

  function automatic bit exp_ready();
    return rdy && !m_flush && !jump_wrong && rob_q.size() < 16 && (!m_dv || dis_ready);
  endfunction

  task automatic model_check();
    bit acc;
    acc = dec_valid && exp_ready();
    chk("dec_ready", 32'(dec_ready), 32'(exp_ready()));
    chk("rf_update_valid", 32'(rf_update_valid), 32'(acc && dec_has_rd && dec_rd != 0));
    if (acc) chk("rf_update_rob_pos", 32'(rf_update_rob_pos), 32'(m_tail));
    chk("dis_valid", 32'(dis_valid), 32'(m_dv));
    if (m_dv) begin
      chk("dis_rob_pos", 32'(dis_rob_pos), 32'(m_pos));
      chk("dis_rd", 32'(dis_rd), 32'(m_rd));
      chk("dis_q1_wait", 32'(dis_q1_wait), 32'(m_o1.w));
      if (m_o1.w) chk("dis_q1", 32'(dis_q1), 32'(m_o1.q));
      else        chk("dis_v1", dis_v1, m_o1.v);
      chk("dis_q2_wait", 32'(dis_q2_wait), 32'(m_o2.w));
      if (m_o2.w) chk("dis_q2", 32'(dis_q2), 32'(m_o2.q));
      else        chk("dis_v2", dis_v2, m_o2.v);
    end
`ifdef DISPATCH_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
`endif
  endtask

  task automatic model_update();
    bit acc;
    acc = dec_valid && exp_ready();
    if (rdy && !m_flush && dec_valid && !exp_ready() && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (jump_wrong) begin
      rob_q.delete(); m_tail = 0; m_dv = 0; m_flush = 1;
    end else begin
      m_flush = 0;
      if (rdy) begin
        if (rob_commit_valid && rob_q.size() > 0) void'(rob_q.pop_front());
        if (acc) begin
          rob_q.push_back(m_tail);
          m_dv = 1; m_pos = m_tail; m_rd = dec_has_rd ? int'(dec_rd) : 0;
          m_o1 = resolve(dec_rs1, rf_reg1_ready, rf_reg1, rf_reg1_rob_pos);
          m_o2 = resolve(dec_rs2, rf_reg2_ready, rf_reg2, rf_reg2_rob_pos);
          m_tail = (m_tail + 1) % 16;
        end else if (m_dv && dis_ready) begin
          m_dv = 0;
        end else if (m_dv && cdb_valid) begin
          if (m_o1.w && m_o1.q == int'(cdb_rob_pos)) begin m_o1.w = 0; m_o1.v = cdb_val; end
          if (m_o2.w && m_o2.q == int'(cdb_rob_pos)) begin m_o2.w = 0; m_o2.v = cdb_val; end
        end
      end
    end
  endtask

  // Inputs are set at posedge+1; peek/cycle sample before the next edge.
  task automatic peek(); #1; endtask
  task automatic cycle(); #2; model_check(); @(posedge clk); model_update(); #1; endtask

  task automatic idle();
    rdy = 1; jump_wrong = 0; dec_valid = 0; dec_has_rd = 1;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 1;
    rf_reg1_ready = 1; rf_reg2_ready = 1; rf_reg1 = 32'h11; rf_reg2 = 32'h22;
    rf_reg1_rob_pos = 0; rf_reg2_rob_pos = 0;
    rob_commit_valid = 0; rob_commit_pos = 0; rob_commit_val = 0;
    cdb_valid = 0; cdb_rob_pos = 0; cdb_val = 0; dis_ready = 1;
  endtask

  task automatic flush();
    idle(); jump_wrong = 1; cycle();
    idle(); cycle();
  endtask

  task automatic accepts(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); dec_valid = 1; dec_rd = 5'(i % 31 + 1); cycle();
    end
  endtask

  bit prev_jw;

  initial begin
    idle();
    rst = 0; dec_valid = 1;
    rob_q.delete(); m_tail = 0; m_flush = 0; m_dv = 0; m_stall = 0;
    #3;
    chk("reset dec_ready", 32'(dec_ready), 0);
    chk("reset rf_update_valid", 32'(rf_update_valid), 0);
    chk("reset dis_valid", 32'(dis_valid), 0);
    chk("reset dis_fields", {dis_rob_pos, dis_rd, dis_q1_wait, dis_q1, dis_q2_wait, dis_q2}, 0);
    chk("reset dis_v1", dis_v1, 0);
    chk("reset dis_v2", dis_v2, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;

    // First instruction: x0 sources, rd=5
    idle(); dec_valid = 1; dec_rd = 5;
    peek();
    chk("t1 upd_valid", 32'(rf_update_valid), 1);
    chk("t1 upd_pos", 32'(rf_update_rob_pos), 0);
    cycle();
    chk("t1 dis_valid", 32'(dis_valid), 1);
    chk("t1 q1_wait", 32'(dis_q1_wait), 0);
    chk("t1 v1", dis_v1, 0);

    // Busy source, then CDB wakeup while held
    idle(); dec_valid = 1; dec_rs1 = 5; rf_reg1_ready = 0; rf_reg1_rob_pos = 0; dec_rd = 6;
    cycle();
    chk("t2 q1_wait", 32'(dis_q1_wait), 1);
    chk("t2 q1", 32'(dis_q1), 0);
    idle(); dis_ready = 0; cdb_valid = 1; cdb_rob_pos = 0; cdb_val = 32'hDEADBEEF;
    cycle();
    chk("t2 wake q1_wait", 32'(dis_q1_wait), 0);
    chk("t2 wake v1", dis_v1, 32'hDEADBEEF);

    // Fill the ROB, then one commit frees a slot at wrapped position 0
    flush();
    accepts(16);
    idle(); dec_valid = 1; dec_rd = 3; rob_commit_valid = 1;
    peek(); chk("full dec_ready", 32'(dec_ready), 0);
    cycle();
    idle(); dec_valid = 1; dec_rd = 3;
    peek();
    chk("after commit dec_ready", 32'(dec_ready), 1);
    chk("17th rob_pos", 32'(rf_update_rob_pos), 0);
    cycle();

    // Accept and commit together at count 7 leaves count at 7
    flush();
    accepts(7);
    idle(); dec_valid = 1; rob_commit_valid = 1; cycle();
    accepts(9);
    idle(); dec_valid = 1;
    peek(); chk("count7 full dec_ready", 32'(dec_ready), 0);
    cycle();

    // rdy low freezes everything
    flush();
    accepts(1);
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 0; dec_valid = 1;
      peek();
      chk("rdy0 upd_valid", 32'(rf_update_valid), 0);
      chk("rdy0 dec_ready", 32'(dec_ready), 0);
      cycle();
    end
    idle(); dec_valid = 1;
    peek(); chk("rdy1 rob_pos", 32'(rf_update_rob_pos), 1);
    cycle();

    // Mispredict with a held instruction and count 9
    flush();
    accepts(9);
    idle(); jump_wrong = 1; dec_valid = 1; dis_ready = 0;
    peek();
    chk("jw dis_valid", 32'(dis_valid), 1);
    chk("jw dec_ready", 32'(dec_ready), 0);
    chk("jw upd_valid", 32'(rf_update_valid), 0);
    cycle();
    idle(); dec_valid = 1;
    peek();
    chk("flush dis_valid", 32'(dis_valid), 0);
    chk("flush dec_ready", 32'(dec_ready), 0);
    cycle();
    idle(); dec_valid = 1;
    peek();
    chk("post-flush dec_ready", 32'(dec_ready), 1);
    chk("post-flush rob_pos", 32'(rf_update_rob_pos), 0);
    cycle();

    // Randomized traffic against the model
    prev_jw = 0;
    for (int n = 0; n < 2000; n++) begin
      rdy        = prev_jw ? 1'b1 : ($urandom_range(0, 9) != 0);
      jump_wrong = rdy && !prev_jw && ($urandom_range(0, 59) == 0);
      prev_jw    = jump_wrong;
      dec_valid  = $urandom_range(0, 3) != 0;
      dec_has_rd = $urandom_range(0, 4) != 0;
      dec_rs1    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      dec_rs2    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      dec_rd     = 5'($urandom_range(0, 31));
      rf_reg1_ready   = $urandom_range(0, 1);
      rf_reg2_ready   = $urandom_range(0, 1);
      rf_reg1         = $urandom;
      rf_reg2         = $urandom;
      rf_reg1_rob_pos = 4'($urandom_range(0, 3));
      rf_reg2_rob_pos = 4'($urandom_range(0, 3));
      cdb_valid       = $urandom_range(0, 1);
      cdb_rob_pos     = 4'($urandom_range(0, 3));
      cdb_val         = $urandom;
      rob_commit_valid = (rob_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                            : (!dec_valid && $urandom_range(0, 1) == 1);
      rob_commit_pos  = 4'($urandom_range(0, 3));
      rob_commit_val  = $urandom;
      dis_ready       = $urandom_range(0, 2) != 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
